counter_sched: RTL

- Scheduler/sequencer that shares one 4-bit `counter` instance (ports CLK, RST_X, COUNTON, CNT4) between NREQ requesters.
- Grants the counter round-robin and clears it before each run.
- Enables counting until the granted requester's programmed length is reached, then pulses that requester's DONE.
- Sits between the requesting blocks and the counter; it is the sole driver of the counter's RST_X and COUNTON.

---
 rtl/counter_sched_pkg.sv | 20 ++
 rtl/counter_sched_rr_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: state encodings and default sizes.
// Imported by the scheduler top and its round-robin arbiter.
package counter_sched_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Width of a requester index; at least one bit even for tiny NREQ.
  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request strictly after
// rr_ptr in circular order, so the last winner always goes to the back of the line.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one external W-bit counter among NREQ requesters: round-robin grant,
// one clear cycle, count up to the owner's latched length, then a one-cycle DONE.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ*W-1:0] LEN,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] DONE,
  output logic            BUSY,
  output logic            CNT_RST_X,
  output logic            COUNTON,
  input  logic [W-1:0]    CNT4,
  output state_t          dbg_state
);

  localparam int IDX_W = idx_width(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     len_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic [W-1:0]     len_sel;
  logic             at_len;

  assign dbg_state = state;
  assign at_len    = (CNT4 == len_q);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (REQ),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Length of whichever requester the arbiter is offering right now.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) len_sel = LEN[i*W +: W];
    end
  end

  always_comb begin
    state_nxt = state;
    CNT_RST_X = 1'b1;
    COUNTON   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|REQ) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        CNT_RST_X = 1'b0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Dropping COUNTON at equality is what keeps a max length from wrapping.
        COUNTON = !at_len;
        if (at_len) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset also clears the shared counter, whatever state we were in.
    if (RST) begin
      CNT_RST_X = 1'b0;
      COUNTON   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      GNT    <= '0;
      DONE   <= '0;
      BUSY   <= 1'b0;
      len_q  <= '0;
      rr_ptr <= IDX_W'(NREQ - 1);
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != ST_IDLE);
      DONE  <= '0;
      case (state)
        ST_IDLE: begin
          if (|REQ) begin
            GNT    <= arb_gnt;
            len_q  <= len_sel;
            rr_ptr <= arb_idx;
          end
        end
        ST_RUN: begin
          if (at_len) DONE <= GNT;
        end
        ST_FIN: begin
          GNT <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
